instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-controller bundle: redirect, downstream instruction handshake,
// byte-wide instruction-memory read port and the fault flag.
// slave = fetch controller, master = surrounding pipeline and memory.
interface instr_fetch_if;
  logic        branch;
  logic [23:0] branch_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [23:0] instruction;
  logic [23:0] instr_pc;
  logic [23:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        fault;

  modport slave (
    input  branch, branch_target, instr_ready, mem_rd_data,
    output instr_valid, instruction, instr_pc, mem_addr, mem_rd_en, fault
  );

  modport master (
    output branch, branch_target, instr_ready, mem_rd_data,
    input  instr_valid, instruction, instr_pc, mem_addr, mem_rd_en, fault
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: reads three bytes per instruction from a
// byte-wide memory (1-cycle read latency) and presents them as one 24-bit word.
// Ports: clk_i, rst_i (async, active-high), fetch_io (instr_fetch_if.slave).
module instr_fetch_ctrl #(
  parameter int          MEM_BYTES = 64,
  parameter logic [23:0] PC_RESET  = 24'h000000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_fetch_if.slave  fetch_io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_RD1   = 3'd2,
    S_RD2   = 3'd3,
    S_CAP   = 3'd4,
    S_VALID = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] pc_q, pc_d;
  logic [23:0] instr_q;
  logic [23:0] instr_pc_q;

  logic        take_branch;
  logic [24:0] pc_plus2_ext;
  logic        pc_oob;

  // Branch is a redirect only once fetching has started.
  assign take_branch = fetch_io.branch && (state_q != S_IDLE);

  // Carry into bit 24 means the last byte wraps past the top of the space.
  assign pc_plus2_ext = {1'b0, pc_q} + 25'd2;
  assign pc_oob       = pc_plus2_ext[24] || (pc_plus2_ext >= 25'(MEM_BYTES));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RD0;
      S_RD0:   state_d = pc_oob ? S_FAULT : S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_CAP;
      S_CAP:   state_d = S_VALID;
      S_VALID: state_d = fetch_io.instr_ready ? S_RD0 : S_VALID;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (take_branch) begin
      state_d = S_RD0;
    end
  end

  // Output logic
  always_comb begin
    fetch_io.mem_rd_en   = 1'b0;
    fetch_io.mem_addr    = pc_q;
    fetch_io.instr_valid = 1'b0;
    fetch_io.fault       = 1'b0;
    case (state_q)
      // An out-of-range line never strobes, not even its first byte.
      S_RD0:   fetch_io.mem_rd_en = !pc_oob;
      S_RD1: begin
        fetch_io.mem_rd_en = 1'b1;
        fetch_io.mem_addr  = pc_q + 24'd1;
      end
      S_RD2: begin
        fetch_io.mem_rd_en = 1'b1;
        fetch_io.mem_addr  = pc_q + 24'd2;
      end
      S_VALID: fetch_io.instr_valid = 1'b1;
      S_FAULT: fetch_io.fault       = 1'b1;
      default: ;
    endcase
  end

  assign fetch_io.instruction = instr_q;
  assign fetch_io.instr_pc    = instr_pc_q;

  // PC: redirect wins over consumption, so a branch together with
  // instr_ready never advances past the presented instruction.
  always_comb begin
    pc_d = pc_q;
    if (take_branch) begin
      pc_d = fetch_io.branch_target;
    end else if (state_q == S_VALID && fetch_io.instr_ready) begin
      pc_d = pc_q + 24'd3;
    end
  end

  // Datapath: each byte is captured the cycle after its address was strobed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= PC_RESET;
      instr_q    <= 24'h000000;
      instr_pc_q <= 24'h000000;
    end else begin
      pc_q <= pc_d;
      if (!take_branch) begin
        case (state_q)
          S_RD1: instr_q[23:16] <= fetch_io.mem_rd_data;
          S_RD2: instr_q[15:8]  <= fetch_io.mem_rd_data;
          S_CAP: begin
            instr_q[7:0] <= fetch_io.mem_rd_data;
            instr_pc_q   <= pc_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch_if bus ();

  instr_fetch_ctrl #(
    .MEM_BYTES (64),
    .PC_RESET  (24'h000000)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fetch_io (bus)
  );

  // Byte-wide instruction memory, one-cycle read latency.
  logic [7:0] mem [0:63];
  always @(posedge clk_i) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= (bus.mem_addr < 24'd64) ? mem[bus.mem_addr[5:0]] : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Bounded wait for instr_valid; checks edge count and presented word.
  task automatic wait_valid(input string tag, input int exp_n,
                            input logic [23:0] exp_instr, input logic [23:0] exp_pc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.instr_valid && n < 20);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_instr"}, {8'h00, bus.instruction}, {8'h00, exp_instr});
    chk({tag, "_pc"}, {8'h00, bus.instr_pc}, {8'h00, exp_pc});
  endtask

  task automatic do_branch(input logic [23:0] tgt, input logic rdy);
    bus.branch        = 1'b1;
    bus.branch_target = tgt;
    bus.instr_ready   = rdy;
    tick();
    bus.branch      = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'h12; mem[1]  = 8'h34; mem[2]  = 8'h56;
    mem[3]  = 8'hAB; mem[4]  = 8'hCD; mem[5]  = 8'hEF;
    mem[6]  = 8'h66; mem[7]  = 8'h77; mem[8]  = 8'h88;
    mem[12] = 8'h11; mem[13] = 8'h22; mem[14] = 8'h33;
    mem[61] = 8'h9A; mem[62] = 8'hBC; mem[63] = 8'hDE;

    rst_i             = 1'b1;
    bus.branch        = 1'b0;
    bus.branch_target = 24'h000000;
    bus.instr_ready   = 1'b0;
    tick();
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_rden",  {31'd0, bus.mem_rd_en}, 32'd0);
    chk("rst_addr",  {8'h00, bus.mem_addr}, 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_instr", {8'h00, bus.instruction}, 32'd0);

    // First fetch after reset, held with instr_ready low.
    rst_i = 1'b0;
    tick();
    chk("rd0_rden", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("rd0_addr", {8'h00, bus.mem_addr}, 32'd0);
    tick();
    chk("rd1_addr", {8'h00, bus.mem_addr}, 32'd1);
    tick();
    chk("rd2_addr", {8'h00, bus.mem_addr}, 32'd2);
    tick();
    chk("cap_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("first_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("first_instr", {8'h00, bus.instruction}, 32'h00123456);
    chk("first_pc",    {8'h00, bus.instr_pc}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("hold_instr", {8'h00, bus.instruction}, 32'h00123456);
    chk("hold_rden",  {31'd0, bus.mem_rd_en}, 32'd0);

    // Streaming with instr_ready high: one instruction per 5 cycles.
    bus.instr_ready = 1'b1;
    wait_valid("stream3", 5, 24'hABCDEF, 24'd3);
    wait_valid("stream6", 5, 24'h667788, 24'd6);
    bus.instr_ready = 1'b0;

    // Redirect to 0, then redirect again while in RD1.
    do_branch(24'h000000, 1'b0);
    chk("br_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("br_addr",  {8'h00, bus.mem_addr}, 32'd0);
    tick();
    chk("br_rd1", {8'h00, bus.mem_addr}, 32'd1);
    do_branch(24'h00000C, 1'b0);
    chk("brrd1_rden", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("brrd1_addr", {8'h00, bus.mem_addr}, 32'd12);
    wait_valid("br12", 4, 24'h112233, 24'd12);

    // Branch and instr_ready together: branch wins, PC does not advance.
    do_branch(24'h000000, 1'b0);
    wait_valid("br0", 4, 24'h123456, 24'd0);
    do_branch(24'h000006, 1'b1);
    chk("brrdy_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("brrdy_addr",  {8'h00, bus.mem_addr}, 32'd6);
    wait_valid("brrdy", 4, 24'h667788, 24'd6);

    // Last in-range line.
    do_branch(24'h00003D, 1'b0);
    wait_valid("edge61", 4, 24'h9ABCDE, 24'd61);

    // Out of range: fault without any strobe, then recover.
    do_branch(24'h00003E, 1'b0);
    chk("oob_rd0_rden",  {31'd0, bus.mem_rd_en}, 32'd0);
    chk("oob_rd0_fault", {31'd0, bus.fault}, 32'd0);
    tick();
    chk("oob_fault", {31'd0, bus.fault}, 32'd1);
    chk("oob_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("oob_rden",  {31'd0, bus.mem_rd_en}, 32'd0);
    tick();
    chk("oob_stay", {31'd0, bus.fault}, 32'd1);
    do_branch(24'h000000, 1'b0);
    chk("rec_fault", {31'd0, bus.fault}, 32'd0);
    chk("rec_rden",  {31'd0, bus.mem_rd_en}, 32'd1);
    wait_valid("rec", 4, 24'h123456, 24'd0);

    // PC+2 wrapping past 2^24 also faults.
    do_branch(24'hFFFFFE, 1'b0);
    chk("wrap_rden", {31'd0, bus.mem_rd_en}, 32'd0);
    tick();
    chk("wrap_fault", {31'd0, bus.fault}, 32'd1);

    // Reset in RD2 clears outputs immediately, without a clock edge.
    do_branch(24'h000000, 1'b0);
    tick();
    tick();
    chk("pre_rst_addr", {8'h00, bus.mem_addr}, 32'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_rden",  {31'd0, bus.mem_rd_en}, 32'd0);
    chk("arst_addr",  {8'h00, bus.mem_addr}, 32'd0);
    chk("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("arst_instr", {8'h00, bus.instruction}, 32'd0);
    chk("arst_pc",    {8'h00, bus.instr_pc}, 32'd0);
    tick();
    chk("arst_hold_rden", {31'd0, bus.mem_rd_en}, 32'd0);

    // Release with a branch pending: ignored while in IDLE.
    rst_i             = 1'b0;
    bus.branch        = 1'b1;
    bus.branch_target = 24'h000030;
    tick();
    bus.branch = 1'b0;
    chk("idle_br_rden", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("idle_br_addr", {8'h00, bus.mem_addr}, 32'd0);
    wait_valid("post_rst", 4, 24'h123456, 24'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
